serial_subtractor: RTL

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_subtractor_pkg.sv | 11 +
 rtl/serial_subtractor_adder_1.sv | 14 +
 rtl/serial_subtractor.sv | 115 +++++++++++
 3 files changed

// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
package serial_subtractor_pkg;

    // Controller states: waiting for operands, stepping through bits, holding the result
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtractor_adder_1.sv
// 1-bit full adder used as the single per-bit slice of the serial subtractor.
module adder_1 (
    input  logic a,
    input  logic b,
    input  logic c_in,
    output logic sum,
    output logic c_out
);

    // Plain combinational full-adder equations
    assign sum   = a ^ b ^ c_in;
    assign c_out = (a & b) | (c_in & (a ^ b));

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: diff = (a - b) mod 2^N computed LSB first as
// a + ~b + 1 using one full-adder slice, one bit per clock, valid/ready on both sides.
module serial_subtractor
    import serial_subtractor_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [N-1:0] diff,
    output logic         borrow
);

    localparam int            IW       = $clog2(N);
    localparam logic [IW-1:0] LAST_IDX = IW'(N - 1);

    state_e        state_q, state_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          carry_q, carry_d;
    logic [N-1:0]  a_q, a_d;
    logic [N-1:0]  b_q, b_d;
    logic [N-1:0]  diff_q, diff_d;
    logic          borrow_q, borrow_d;

    logic          sliceA;
    logic          sliceB;
    logic          sliceSum;
    logic          sliceCout;

    // The slice sees the current bit of the minuend and the inverted subtrahend bit;
    // the carry register seeded with 1 supplies the +1 of the two's complement.
    assign sliceA = a_q[idx_q];
    assign sliceB = ~b_q[idx_q];

    adder_1 u_slice (
        .a     (sliceA),
        .b     (sliceB),
        .c_in  (carry_q),
        .sum   (sliceSum),
        .c_out (sliceCout)
    );

    // Next-state and datapath update: latch on accept, one bit per RUN cycle, hold in DONE
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        carry_d  = carry_q;
        a_d      = a_q;
        b_d      = b_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    a_d     = a;
                    b_d     = b;
                    idx_d   = '0;
                    carry_d = 1'b1;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                diff_d[idx_q] = sliceSum;
                carry_d       = sliceCout;
                if (idx_q == LAST_IDX) begin
                    borrow_d = ~sliceCout;
                    state_d  = S_DONE;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            S_DONE: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset discards any operation in flight
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            idx_q    <= '0;
            carry_q  <= 1'b1;
            a_q      <= '0;
            b_q      <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            carry_q  <= carry_d;
            a_q      <= a_d;
            b_q      <= b_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = (state_q == S_DONE);
    assign diff      = diff_q;
    assign borrow    = borrow_q;

endmodule
